// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX <-> branch resolve bundle: IF prediction, EX outcome,
// redirect and BTB update. master = pipeline side, slave = resolver.
interface branch_resolve_unit_if #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 9,
  parameter int TAG_BITS = 7
);
  logic                stall;
  logic                fetch_valid;
  logic [XLEN-1:0]     pc_if;
  logic                pred_taken_if;
  logic [XLEN-1:0]     pred_target_if;
  logic                branch_ex;
  logic                jump_ex;
  logic                take_branch_ex;
  logic [XLEN-1:0]     target_ex;
  logic                mispredict;
  logic [XLEN-1:0]     redirect_pc;
  logic                flush_id;
  logic                upd_valid;
  logic [IDX_BITS-1:0] upd_index;
  logic [TAG_BITS-1:0] upd_tag;
  logic [XLEN-1:0]     upd_target;
  logic                upd_taken;

  modport master (
    output stall, fetch_valid, pc_if,
    output pred_taken_if, pred_target_if,
    output branch_ex, jump_ex,
    output take_branch_ex, target_ex,
    input  mispredict, redirect_pc, flush_id,
    input  upd_valid, upd_index, upd_tag,
    input  upd_target, upd_taken
  );

  modport slave (
    input  stall, fetch_valid, pc_if,
    input  pred_taken_if, pred_target_if,
    input  branch_ex, jump_ex,
    input  take_branch_ex, target_ex,
    output mispredict, redirect_pc, flush_id,
    output upd_valid, upd_index, upd_tag,
    output upd_target, upd_taken
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries fetch predictions IF->ID->EX, resolves them at EX
// (redirect on mispredict) and emits a registered BTB update.
// Ports: clk, rst_n (async low), bus (slave modport).
// BRU_PERF_CNT_EN adds br_count / mispred_count outputs.
module branch_resolve_unit #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 9,
  parameter int TAG_BITS = 7
) (
  input logic clk,
  input logic rst_n,
  branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
`endif
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } stage_t;

  stage_t id_q, ex_q, id_d, ex_d;
  logic   resolved_q;
  logic   flush_pend_q;
  logic   flush;

  logic            actual_taken;
  logic            is_cf;
  logic            wrong_dir;
  logic            wrong_tgt;
  logic            mispredict;
  logic [XLEN-1:0] pc4;
  logic            upd_fire;

  logic                upd_valid_q;
  logic [IDX_BITS-1:0] upd_index_q;
  logic [TAG_BITS-1:0] upd_tag_q;
  logic [XLEN-1:0]     upd_target_q;
  logic                upd_taken_q;

  always_comb begin
    actual_taken = bus.jump_ex
                 | (bus.branch_ex & bus.take_branch_ex);
    is_cf        = bus.branch_ex | bus.jump_ex;
    pc4          = ex_q.pc + XLEN'(4);
    wrong_dir    = actual_taken ^ ex_q.pred_taken;
    wrong_tgt    = actual_taken & ex_q.pred_taken
                 & (bus.target_ex != ex_q.pred_target);
    mispredict   = ex_q.valid & ~resolved_q
                 & (wrong_dir | wrong_tgt);
    upd_fire     = ex_q.valid & is_cf & ~resolved_q;
  end

  // A mispredict seen while stalled pulses once; the squash
  // of ID/EX is remembered and applied when stall drops.
  always_comb begin
    flush             = mispredict | flush_pend_q;
    id_d.valid        = bus.fetch_valid & ~flush;
    id_d.pc           = bus.pc_if;
    id_d.pred_taken   = bus.pred_taken_if;
    id_d.pred_target  = bus.pred_target_if;
    ex_d              = id_q;
    ex_d.valid        = id_q.valid & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q         <= '0;
      ex_q         <= '0;
      resolved_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else if (!bus.stall) begin
      id_q         <= id_d;
      ex_q         <= ex_d;
      resolved_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      resolved_q   <= resolved_q | ex_q.valid;
      flush_pend_q <= flush_pend_q | mispredict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_tag_q    <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      upd_valid_q <= upd_fire;
      if (upd_fire) begin
        upd_index_q  <= ex_q.pc[IDX_BITS-1:0];
        upd_tag_q    <= ex_q.pc[IDX_BITS+TAG_BITS-1:IDX_BITS];
        upd_target_q <= bus.target_ex;
        upd_taken_q  <= actual_taken;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (upd_valid_q && br_count != '1)
        br_count <= br_count + 32'd1;
      if (mispredict && mispred_count != '1)
        mispred_count <= mispred_count + 32'd1;
    end
  end
`endif

  assign bus.mispredict  = mispredict;
  assign bus.flush_id    = mispredict;
  assign bus.redirect_pc = (mispredict & actual_taken)
                         ? bus.target_ex : pc4;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_index   = upd_index_q;
  assign bus.upd_tag     = upd_tag_q;
  assign bus.upd_target  = upd_target_q;
  assign bus.upd_taken   = upd_taken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push
// expected redirects/updates; a negedge monitor pops and compares.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  branch_resolve_unit_if bus();

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_count, mispred_count;
`endif

  branch_resolve_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRU_PERF_CNT_EN
    ,
    .br_count      (br_count),
    .mispred_count (mispred_count)
`endif
  );

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        d;
  } exp_t;

  exp_t mis_q[$];
  exp_t upd_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.mispredict === 1'b1) begin
      if (mis_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mispredict cyc=%0d actual=1 expected=0",
                 cyc);
      end else begin
        e = mis_q.pop_front();
        chk("mis_cycle", cyc, e.cyc);
        chk("redirect_pc", bus.redirect_pc, e.a);
        chk("flush_id", {31'd0, bus.flush_id}, 32'd1);
      end
    end
    if (bus.upd_valid === 1'b1) begin
      if (upd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd cyc=%0d actual=1 expected=0",
                 cyc);
      end else begin
        e = upd_q.pop_front();
        chk("upd_cycle", cyc, e.cyc);
        chk("upd_index", {23'd0, bus.upd_index}, e.a);
        chk("upd_tag", {25'd0, bus.upd_tag}, e.b);
        chk("upd_target", bus.upd_target, e.c);
        chk("upd_taken", {31'd0, bus.upd_taken}, {31'd0, e.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic fv, input logic [31:0] pc,
                     input logic pt, input logic [31:0] ptg,
                     input logic br, input logic jp,
                     input logic tk, input logic [31:0] tgt,
                     input logic st);
    bus.fetch_valid    = fv;
    bus.pc_if          = pc;
    bus.pred_taken_if  = pt;
    bus.pred_target_if = ptg;
    bus.branch_ex      = br;
    bus.jump_ex        = jp;
    bus.take_branch_ex = tk;
    bus.target_ex      = tgt;
    bus.stall          = st;
  endtask

  // Instruction enters IF at cycle c, is in EX at c+2 (held nst
  // extra cycles by stall). wp puts predicted-taken junk behind it,
  // which must be squashed whenever it mispredicts.
  task automatic run(input logic [31:0] pc, input logic pt,
                     input logic [31:0] ptg, input logic br,
                     input logic jp, input logic tk,
                     input logic [31:0] tgt, input logic wp,
                     input int nst, input logic em,
                     input logic [31:0] ered, input logic eu,
                     input logic [31:0] eidx, input logic [31:0] etag,
                     input logic [31:0] etgt, input logic etk);
    exp_t e;
    drv(1'b1, pc, pt, ptg, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    drv(wp, pc + 32'd4, 1'b1, pc + 32'h80,
        1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    if (em) begin
      e = '{cyc: cyc, a: ered, b: 32'd0, c: 32'd0, d: 1'b0};
      mis_q.push_back(e);
    end
    if (eu) begin
      e = '{cyc: cyc + 1, a: eidx, b: etag, c: etgt, d: etk};
      upd_q.push_back(e);
    end
    for (int i = 0; i <= nst; i++) begin
      drv(wp, pc + 32'd8, 1'b1, pc + 32'h90,
          br, jp, tk, tgt, i < nst);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 32'd0, 1'b0, 32'd0,
          1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end
  endtask

  task automatic chk_reset_outs;
    chk("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    chk("rst_flush_id", {31'd0, bus.flush_id}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd4);
    chk("rst_upd_valid", {31'd0, bus.upd_valid}, 32'd0);
    chk("rst_upd_index", {23'd0, bus.upd_index}, 32'd0);
    chk("rst_upd_tag", {25'd0, bus.upd_tag}, 32'd0);
    chk("rst_upd_target", bus.upd_target, 32'd0);
    chk("rst_upd_taken", {31'd0, bus.upd_taken}, 32'd0);
  endtask

  initial begin
    exp_t e;
    drv(1'b0, 32'd0, 1'b0, 32'd0,
        1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    chk_reset_outs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h140,
        1'b1, 0, 1'b1, 32'h140,
        1'b1, 32'h100, 32'd0, 32'h140, 1'b1);
    run(32'h200, 1'b1, 32'h240, 1'b1, 1'b0, 1'b0, 32'h240,
        1'b1, 2, 1'b1, 32'h204,
        1'b1, 32'h000, 32'd1, 32'h240, 1'b0);
    run(32'h300, 1'b1, 32'h380, 1'b0, 1'b1, 1'b0, 32'h3C0,
        1'b1, 0, 1'b1, 32'h3C0,
        1'b1, 32'h100, 32'd1, 32'h3C0, 1'b1);
    run(32'h400, 1'b1, 32'h480, 1'b0, 1'b0, 1'b0, 32'h480,
        1'b1, 0, 1'b1, 32'h404,
        1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    run(32'h500, 1'b1, 32'h540, 1'b1, 1'b0, 1'b1, 32'h540,
        1'b0, 3, 1'b0, 32'd0,
        1'b1, 32'h100, 32'd2, 32'h540, 1'b1);
    run(32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h640,
        1'b0, 0, 1'b0, 32'd0,
        1'b1, 32'h000, 32'd3, 32'h640, 1'b0);
    run(32'h700, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h720,
        1'b1, 0, 1'b1, 32'h720,
        1'b1, 32'h100, 32'd3, 32'h720, 1'b1);

    // PC wrap under stall, then reset while still stalled.
    drv(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10,
        1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    drv(1'b0, 32'd0, 1'b0, 32'd0,
        1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    e = '{cyc: cyc, a: 32'h0, b: 32'd0, c: 32'd0, d: 1'b0};
    mis_q.push_back(e);
    e = '{cyc: cyc + 1, a: 32'h1FC, b: 32'h7F, c: 32'h40, d: 1'b0};
    upd_q.push_back(e);
    drv(1'b0, 32'd0, 1'b0, 32'd0,
        1'b1, 1'b0, 1'b0, 32'h40, 1'b1);
    tick();
    tick();
    chk("pre_rst_upd_index", {23'd0, bus.upd_index}, 32'h1FC);
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    tick();
    drv(1'b0, 32'd0, 1'b0, 32'd0,
        1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    chk("mis_q_empty", mis_q.size(), 32'd0);
    chk("upd_q_empty", upd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
